// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for a multicycle RISC-V datapath.
// Sequences fetch / decode / execute / memory / writeback over several clocks
// with one shared ALU and one memory port, using a mem_ready handshake.
// Optional feature macro: BRANCH_EXT_EN (full branch funct3 decode using lt/ltu).
// MEM_WAIT_MAX > 0 adds a wait counter that faults a stalled memory access.
module multicycle_controller #(
    parameter int ALUCTRL_W    = 3,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic                 reg_write,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 fault,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     state_reg;
    logic       funct_ok;
    logic [2:0] funct_ctrl;
    logic       branch_ok;
    logic       branch_taken;
    logic       timeout;
    logic       mem_req_s;
    logic       pc_write_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic [2:0] alu_ctrl_s;

    // ALU operation for R/I-type execute; unknown funct3 is illegal
    always_comb begin
        funct_ok   = 1'b1;
        funct_ctrl = 3'b000;
        case (funct3)
            3'b000:  funct_ctrl = (funct7b5 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  funct_ctrl = 3'b101;
            3'b110:  funct_ctrl = 3'b011;
            3'b111:  funct_ctrl = 3'b010;
            default: funct_ok   = 1'b0;
        endcase
    end

`ifdef BRANCH_EXT_EN
    // Full conditional-branch decode from the ALU flags
    always_comb begin
        branch_ok    = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = ~ltu;
            default: branch_ok    = 1'b0;
        endcase
    end
`else
    // Every branch behaves as beq; the compare flags are not needed
    assign branch_ok    = 1'b1;
    assign branch_taken = zero;
    logic unused_branch_flags;
    assign unused_branch_flags = lt ^ ltu;
`endif

    generate
        if (MEM_WAIT_MAX > 0) begin : g_wait
            localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
            logic [7:0] wait_cnt_reg;
            logic       mem_wait;
            assign mem_wait = mem_req_s & ~mem_ready;
            // Count stalled memory cycles; a waiting state only leaves on ready or timeout
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wait_cnt_reg <= 8'd0;
                end else if (!mem_wait || timeout) begin
                    wait_cnt_reg <= 8'd0;
                end else begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                end
            end
            assign timeout = mem_wait && (wait_cnt_reg == WAIT_LAST);
        end else begin : g_no_wait
            assign timeout = 1'b0;
        end
    endgenerate

    // Main sequencing FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
        end else if (timeout) begin
            state_reg <= S_FAULT;
        end else begin
            case (state_reg)
                S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
                        OP_RTYPE:          state_reg <= S_EXECUTER;
                        OP_ITYPE:          state_reg <= S_EXECUTEI;
                        OP_BRANCH:         state_reg <= S_BRANCH;
                        OP_JAL:            state_reg <= S_JAL;
                        default:           state_reg <= S_FAULT;
                    endcase
                end
                S_MEMADR:   state_reg <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWB:    state_reg <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state_reg <= S_FETCH;
                S_EXECUTER,
                S_EXECUTEI: state_reg <= funct_ok ? S_ALUWB : S_FAULT;
                S_ALUWB:    state_reg <= S_FETCH;
                S_BRANCH:   state_reg <= branch_ok ? S_FETCH : S_FAULT;
                S_JAL:      state_reg <= S_ALUWB;
                S_FAULT:    state_reg <= S_FAULT;
                default:    state_reg <= S_FAULT;
            endcase
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        mem_req_s   = 1'b0;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_ctrl_s  = 3'b000;
        case (state_reg)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_s = mem_ready;
                ir_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = op[5] ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src   = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a  = 2'b10;
                alu_ctrl_s = funct_ctrl;
            end
            S_EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_ctrl_s = funct_ctrl;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_ctrl_s = 3'b001;
                pc_write_s = branch_ok & branch_taken;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Upper ALU-control bits are always zero
    always_comb begin
        alu_control      = '0;
        alu_control[2:0] = alu_ctrl_s;
    end

    // Enables are forced low for as long as reset is held
    assign mem_req   = mem_req_s & rst;
    assign pc_write  = pc_write_s & rst;
    assign ir_write  = ir_write_s & rst;
    assign mem_write = mem_write_s & rst;
    assign reg_write = reg_write_s & rst;
    assign fault     = (state_reg == S_FAULT);
    assign state     = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction expected cycle traces
// built from the instruction class, checked every cycle, plus literal checks.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst4;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready, mr4;

    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, fault;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic       mem_req4, pc_write4, ir_write4, fault4;
    logic       d4_unused_adr_src, d4_unused_mem_write, d4_unused_reg_write;
    logic [1:0] d4_unused_result_src, d4_unused_src_a, d4_unused_src_b, d4_unused_imm_src;
    logic [3:0] alu_control4;
    logic [3:0] state4;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .fault(fault), .state(state)
    );

    multicycle_controller #(.ALUCTRL_W(4), .MEM_WAIT_MAX(4)) dut4 (
        .clk(clk), .rst(rst4), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mr4),
        .mem_req(mem_req4), .pc_write(pc_write4), .adr_src(d4_unused_adr_src),
        .mem_write(d4_unused_mem_write), .ir_write(ir_write4),
        .result_src(d4_unused_result_src), .alu_src_a(d4_unused_src_a),
        .alu_src_b(d4_unused_src_b), .imm_src(d4_unused_imm_src),
        .reg_write(d4_unused_reg_write), .alu_control(alu_control4),
        .fault(fault4), .state(state4)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, pcw, irw, mw, rw, flt;
        logic       c_adr, adr;
        logic       c_src;
        logic [1:0] srca, srcb;
        logic       c_imm;
        logic [1:0] imm;
        logic       c_aluc;
        logic [2:0] aluc;
        logic       c_rsrc;
        logic [1:0] rsrc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rw_cnt   = 0;
    int   mw_cnt   = 0;
    int   brpc_cnt = 0;
    int   cyc      = 0;
    logic [2:0] last_ex = 3'b000;

    // Per-instruction context used when building the expected trace
    logic [2:0] m_aluc;
    logic       m_caluc, m_taken, m_store;

    // Expected outputs for one cycle spent in a given state (state numbering is
    // the documented debug encoding)
    function automatic exp_t exp_of(input int st, input logic ready);
        exp_t e;
        e    = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mreq = 1; e.c_adr = 1; e.adr = 0; e.c_src = 1; e.srca = 2'b00; e.srcb = 2'b10;
                      e.c_aluc = 1; e.aluc = 3'b000; e.c_rsrc = 1; e.rsrc = 2'b10;
                      e.pcw = ready; e.irw = ready; end
            1:  begin e.c_src = 1; e.srca = 2'b01; e.srcb = 2'b01; e.c_aluc = 1; e.aluc = 3'b000;
                      e.c_imm = 1; e.imm = 2'b10; end
            2:  begin e.c_src = 1; e.srca = 2'b10; e.srcb = 2'b01; e.c_aluc = 1; e.aluc = 3'b000;
                      e.c_imm = 1; e.imm = m_store ? 2'b01 : 2'b00; end
            3:  begin e.mreq = 1; e.c_adr = 1; e.adr = 1; e.c_rsrc = 1; e.rsrc = 2'b00; end
            4:  begin e.rw = 1; e.c_rsrc = 1; e.rsrc = 2'b01; end
            5:  begin e.mreq = 1; e.mw = 1; e.c_adr = 1; e.adr = 1; e.c_rsrc = 1; e.rsrc = 2'b00; end
            6:  begin e.c_src = 1; e.srca = 2'b10; e.srcb = 2'b00; e.c_aluc = m_caluc; e.aluc = m_aluc; end
            7:  begin e.c_src = 1; e.srca = 2'b10; e.srcb = 2'b01; e.c_imm = 1; e.imm = 2'b00;
                      e.c_aluc = m_caluc; e.aluc = m_aluc; end
            8:  begin e.rw = 1; e.c_rsrc = 1; e.rsrc = 2'b00; end
            9:  begin e.c_src = 1; e.srca = 2'b10; e.srcb = 2'b00; e.c_aluc = 1; e.aluc = 3'b001;
                      e.c_rsrc = 1; e.rsrc = 2'b00; e.pcw = m_taken; end
            10: begin e.c_src = 1; e.srca = 2'b01; e.srcb = 2'b10; e.c_aluc = 1; e.aluc = 3'b000;
                      e.c_rsrc = 1; e.rsrc = 2'b00; e.pcw = 1; end
            default: e.flt = 1;
        endcase
        return e;
    endfunction

    // ALU operation required for an execute step: {legal, code}
    function automatic logic [3:0] alu_model(input logic [2:0] f3, input logic f7, input logic op5);
        case (f3)
            3'b000:  return {1'b1, (f7 && op5) ? 3'b001 : 3'b000};
            3'b010:  return 4'b1101;
            3'b110:  return 4'b1011;
            3'b111:  return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    // Branch outcome: {legal, taken}
    function automatic logic [1:0] br_model(input logic [2:0] f3, input logic z, input logic l, input logic lu);
`ifdef BRANCH_EXT_EN
        case (f3)
            3'b000:  return {1'b1, z};
            3'b001:  return {1'b1, ~z};
            3'b100:  return {1'b1, l};
            3'b101:  return {1'b1, ~l};
            3'b110:  return {1'b1, lu};
            3'b111:  return {1'b1, ~lu};
            default: return 2'b00;
        endcase
`else
        if (f3 == 3'b111 && l && lu) return {1'b1, z};
        return {1'b1, z};
`endif
    endfunction

    // Per-cycle comparison against the expected trace
    exp_t ce;
    logic cbad;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (reg_write) rw_cnt++;
        if (mem_write) mw_cnt++;
        if (state == 4'd9 && pc_write) brpc_cnt++;
        if (state == 4'd6) last_ex = alu_control;
        if (exp_q.size() > 0) begin
            ce   = exp_q.pop_front();
            cbad = (state != ce.st) || (mem_req != ce.mreq) || (pc_write != ce.pcw) ||
                   (ir_write != ce.irw) || (mem_write != ce.mw) || (reg_write != ce.rw) ||
                   (fault != ce.flt) ||
                   (ce.c_adr && adr_src != ce.adr) ||
                   (ce.c_src && (alu_src_a != ce.srca || alu_src_b != ce.srcb)) ||
                   (ce.c_imm && imm_src != ce.imm) ||
                   (ce.c_aluc && alu_control != ce.aluc) ||
                   (ce.c_rsrc && result_src != ce.rsrc);
            n_checks++;
            if (cbad)
                $display("FAIL cycle%0d: got st=%0d req=%b pcw=%b irw=%b mw=%b rw=%b flt=%b adr=%b a=%b b=%b imm=%b alu=%b rs=%b; want st=%0d req=%b pcw=%b irw=%b mw=%b rw=%b flt=%b adr=%b a=%b b=%b imm=%b alu=%b rs=%b",
                         cyc, state, mem_req, pc_write, ir_write, mem_write, reg_write, fault,
                         adr_src, alu_src_a, alu_src_b, imm_src, alu_control, result_src,
                         ce.st, ce.mreq, ce.pcw, ce.irw, ce.mw, ce.rw, ce.flt,
                         ce.adr, ce.srca, ce.srcb, ce.imm, ce.aluc, ce.rsrc);
            else
                n_pass++;
        end
    end

    task automatic check_lit(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    task automatic step(input int st, input logic ready);
        mem_ready = ready;
        exp_q.push_back(exp_of(st, ready));
        @(posedge clk);
        #1;
    endtask

    // One instruction: fw fetch stalls, mw data-memory stalls, nfault cycles checked in FAULT
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input int nfault);
        logic [3:0] am;
        logic [1:0] bm;
        int         n = 0;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        m_aluc = 3'b000; m_caluc = 1'b0; m_taken = 1'b0; m_store = o[5];
        for (int i = 0; i < fw; i++) begin step(0, 1'b0); n++; end
        step(0, 1'b1);
        step(1, 1'b1);
        n += 2;
        case (o)
            7'b0000011: begin
                step(2, 1'b1);
                for (int i = 0; i < mw; i++) step(3, 1'b0);
                step(3, 1'b1);
                step(4, 1'b1);
                n += 3 + mw;
            end
            7'b0100011: begin
                step(2, 1'b1);
                for (int i = 0; i < mw; i++) step(5, 1'b0);
                step(5, 1'b1);
                n += 2 + mw;
            end
            7'b0110011, 7'b0010011: begin
                am      = alu_model(f3, f7, o[5]);
                m_aluc  = am[2:0];
                m_caluc = am[3];
                step(o[5] ? 6 : 7, 1'b1);
                n++;
                if (am[3]) begin step(8, 1'b1); n++; end
                else for (int i = 0; i < nfault; i++) begin step(11, 1'b1); n++; end
            end
            7'b1100011: begin
                bm      = br_model(f3, z, lt, ltu);
                m_taken = bm[1] & bm[0];
                step(9, 1'b1);
                n++;
                if (!bm[1]) for (int i = 0; i < nfault; i++) begin step(11, 1'b1); n++; end
            end
            7'b1101111: begin
                step(10, 1'b1);
                step(8, 1'b1);
                n += 2;
            end
            default: for (int i = 0; i < nfault; i++) begin step(11, 1'b1); n++; end
        endcase
        $display("txn op=%b funct3=%b f7b5=%b zero=%b fetch_waits=%0d mem_waits=%0d: %0d cycles traced",
                 o, f3, f7, z, fw, mw, n);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        check_lit("reset_state", int'(state), 0);
        check_lit("reset_fault", int'(fault), 0);
        check_lit("reset_mem_req", int'(mem_req), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    initial begin
        int b;
        rst = 1'b0; rst4 = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0; mr4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        check_lit("rst_state", int'(state), 0);
        check_lit("rst_mem_req", int'(mem_req), 0);
        check_lit("rst_pc_write", int'(pc_write), 0);
        check_lit("rst_ir_write", int'(ir_write), 0);
        check_lit("rst_mem_write", int'(mem_write), 0);
        check_lit("rst_reg_write", int'(reg_write), 0);
        check_lit("rst_fault", int'(fault), 0);
        rst = 1'b1;

        b = rw_cnt;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 0);
        check_lit("lw_reg_write_cycles", rw_cnt - b, 1);
        check_lit("lw_back_to_fetch", int'(state), 0);

        b = mw_cnt;
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, 0);
        check_lit("sw_mem_write_cycles", mw_cnt - b, 4);
        check_lit("sw_no_fault", int'(fault), 0);

        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 0);
        check_lit("r_sub_alu", int'(last_ex), 1);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        check_lit("r_add_alu", int'(last_ex), 0);
        run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0, 0);
        check_lit("r_and_alu", int'(last_ex), 2);
        run_instr(RT, 3'b010, 1'b0, 1'b0, 0, 0, 0);
        run_instr(RT, 3'b110, 1'b1, 1'b0, 0, 0, 0);
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, 0);
        run_instr(IT, 3'b111, 1'b0, 1'b0, 0, 0, 0);

        b = brpc_cnt;
        run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, 0);
        check_lit("beq_taken", brpc_cnt - b, 1);
        b = brpc_cnt;
        run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        check_lit("beq_not_taken", brpc_cnt - b, 0);
`ifdef BRANCH_EXT_EN
        b = brpc_cnt;
        run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0, 0);
        check_lit("bne_taken", brpc_cnt - b, 1);
`endif

        run_instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 2, 1, 0);

        run_instr(BAD, 3'b000, 1'b0, 1'b0, 0, 0, 10);
        check_lit("fault_sticky", int'(fault), 1);
        pulse_reset();

        run_instr(RT, 3'b001, 1'b0, 1'b0, 0, 0, 2);
        pulse_reset();

        // Reset asserted in the middle of a load's memory read
        op = LW; funct3 = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check_lit("abort_in_memread", int'(state), 3);
        b = rw_cnt;
        #2 rst = 1'b0;
        #1;
        check_lit("abort_state_async", int'(state), 0);
        check_lit("abort_reg_write", int'(reg_write), 0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_lit("abort_refetch", int'(state), 1);
        check_lit("abort_no_writeback", rw_cnt - b, 0);

        // Fetch stall with a 4-cycle wait limit
        rst4 = 1'b1;
        #1;
        check_lit("wait_start_state", int'(state4), 0);
        check_lit("wait_alu_wide", int'(alu_control4), 0);
        check_lit("wait_pc_write", int'(pc_write4), 0);
        check_lit("wait_ir_write", int'(ir_write4), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_lit("wait_still_fetch", int'(state4), 0);
        end
        @(posedge clk); #1;
        check_lit("wait_timeout_state", int'(state4), 11);
        check_lit("wait_timeout_fault", int'(fault4), 1);
        check_lit("wait_timeout_mem_req", int'(mem_req4), 0);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
